sum_accum_tree: RTL and testbench

- Pipelined, parametrised unsigned reduction tree for the softmax datapath.
- Sums NUM_INPUTS lanes per beat and accumulates beats until a last marker, so rows longer than the lane count can be reduced.
- Emits one total per row with a valid/ready handshake.
- Sits between the exponent stage and the normaliser; the row sum feeds the reciprocal/divide.

---
 rtl/sum_accum_tree.sv | 137 +++++++++++++
 tb/tb_sum_accum_tree.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accum_tree.sv
// Unsigned lane-reduction tree plus row accumulator; one total per in_last-terminated row. SUM_SAT_EN enables saturation.
// Latency: last beat accepted in cycle t -> out_valid in cycle t+NUM_STAGES+1; one beat per cycle.
// Backpressure: a held result (out_valid && !out_ready) freezes the whole pipe and drops in_ready.
module sum_accum_tree #(
    parameter int NUM_INPUTS = 8,
    parameter int DATA_WIDTH = 16,
    parameter int SUM_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [SUM_WIDTH-1:0]             out_sum,
    output logic [CNT_WIDTH-1:0]             out_count,
    output logic                             out_ovf,
    output logic                             out_valid,
    input  logic                             out_ready
);
    localparam int NUM_STAGES = $clog2(NUM_INPUTS);
    localparam int PAD        = 1 << NUM_STAGES;
    localparam int TW         = DATA_WIDTH + NUM_STAGES;

    logic stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Lanes are zero-padded to PAD, so an odd leftover simply adds zero and flows through.
    for (genvar s = 0; s <= NUM_STAGES; s++) begin : g_lvl
        localparam int N = PAD >> s;
        logic [N*TW-1:0] dat;
        logic            vld;
        logic            lst;

        if (s == 0) begin : g_in
            always_comb begin
                dat = '0;
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    dat[i*TW +: TW] = TW'(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
            assign vld = in_valid;
            assign lst = in_last;
        end else begin : g_add
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld <= 1'b0;
                    lst <= 1'b0;
                    dat <= '0;
                end else if (!stall) begin
                    vld <= g_lvl[s-1].vld;
                    lst <= g_lvl[s-1].vld && g_lvl[s-1].lst;
                    for (int i = 0; i < N; i++) begin
                        dat[i*TW +: TW] <= g_lvl[s-1].dat[(2*i)*TW +: TW]
                                         + g_lvl[s-1].dat[(2*i+1)*TW +: TW];
                    end
                end
            end
        end
    end

    logic [TW-1:0]        tree_sum;
    logic                 tree_vld;
    logic                 tree_lst;
    logic [SUM_WIDTH-1:0] tree_ext;
    logic [SUM_WIDTH-1:0] acc;
    logic [SUM_WIDTH-1:0] acc_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 beat;

    assign tree_sum = g_lvl[NUM_STAGES].dat;
    assign tree_vld = g_lvl[NUM_STAGES].vld;
    assign tree_lst = g_lvl[NUM_STAGES].lst;
    assign tree_ext = SUM_WIDTH'(tree_sum);
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    assign beat     = tree_vld && !stall;

`ifdef SUM_SAT_EN
    logic [SUM_WIDTH:0] sum_wide;
    logic               row_ovf;
    logic               nxt_ovf;

    // Once a row has overflowed it stays pinned at all-ones until its last beat.
    always_comb begin
        sum_wide = {1'b0, acc} + {1'b0, tree_ext};
        nxt_ovf  = row_ovf || sum_wide[SUM_WIDTH];
        acc_nxt  = nxt_ovf ? '1 : sum_wide[SUM_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_ovf <= 1'b0;
            out_ovf <= 1'b0;
        end else if (beat) begin
            if (tree_lst) begin
                row_ovf <= 1'b0;
                out_ovf <= nxt_ovf;
            end else begin
                row_ovf <= nxt_ovf;
            end
        end
    end
`else
    assign acc_nxt = acc + tree_ext;
    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (beat) begin
                if (tree_lst) begin
                    out_sum   <= acc_nxt;
                    out_count <= cnt_inc;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_nxt;
                    cnt <= cnt_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_sum_accum_tree.sv
// Scoreboard bench for sum_accum_tree: 8-lane/32-bit, 5-lane/32-bit and 8-lane/20-bit instances.
module tb_sum_accum_tree;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instances A (32-bit) and C (20-bit) share one input stream.
    logic [8*DW-1:0] a_data  = '0;
    logic            a_valid = 1'b0;
    logic            a_last  = 1'b0;
    logic            out_ready = 1'b1;
    logic            a_ready, a_ovf, a_ovalid;
    logic [31:0]     a_sum;
    logic [15:0]     a_cnt;
    logic            c_ready, c_ovf, c_ovalid;
    logic [19:0]     c_sum;
    logic [15:0]     c_cnt;

    logic [5*DW-1:0] b_data  = '0;
    logic            b_valid = 1'b0;
    logic            b_last  = 1'b0;
    logic            b_ready, b_ovf, b_ovalid;
    logic [31:0]     b_sum;
    logic [15:0]     b_cnt;

    sum_accum_tree #(.NUM_INPUTS(8), .DATA_WIDTH(16), .SUM_WIDTH(32), .CNT_WIDTH(16)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
        .in_ready(a_ready), .out_sum(a_sum), .out_count(a_cnt), .out_ovf(a_ovf),
        .out_valid(a_ovalid), .out_ready(out_ready));

    sum_accum_tree #(.NUM_INPUTS(5), .DATA_WIDTH(16), .SUM_WIDTH(32), .CNT_WIDTH(16)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
        .in_ready(b_ready), .out_sum(b_sum), .out_count(b_cnt), .out_ovf(b_ovf),
        .out_valid(b_ovalid), .out_ready(out_ready));

    sum_accum_tree #(.NUM_INPUTS(8), .DATA_WIDTH(16), .SUM_WIDTH(20), .CNT_WIDTH(16)) u_c (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
        .in_ready(c_ready), .out_sum(c_sum), .out_count(c_cnt), .out_ovf(c_ovf),
        .out_valid(c_ovalid), .out_ready(out_ready));

    typedef struct {
        logic [31:0] sum;
        int          cnt;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   a_acc = 0;
    int   b_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] sum, input int cnt, input logic ovf, input int cy);
        exp_t e;
        e.sum = sum;
        e.cnt = cnt;
        e.ovf = ovf;
        e.cyc = cy;
        return e;
    endfunction

    // Monitors: compare on every output handshake, independent of the stimulus.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst && a_ovalid && out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got sum 0x%0h with no row pending", a_sum);
            end else begin
                e = qa.pop_front();
                chk("a_sum", a_sum, e.sum);
                chk("a_count", 32'(a_cnt), 32'(e.cnt));
                chk("a_ovf", {31'b0, a_ovf}, {31'b0, e.ovf});
                if (e.cyc >= 0) chk("a_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst && b_ovalid && out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got sum 0x%0h with no row pending", b_sum);
            end else begin
                e = qb.pop_front();
                chk("b_sum", b_sum, e.sum);
                chk("b_count", 32'(b_cnt), 32'(e.cnt));
                chk("b_ovf", {31'b0, b_ovf}, {31'b0, e.ovf});
                if (e.cyc >= 0) chk("b_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (!rst && c_ovalid && out_ready) begin
            if (qc.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_unexpected: got sum 0x%0h with no row pending", c_sum);
            end else begin
                e = qc.pop_front();
                chk("c_sum", 32'(c_sum), e.sum);
                chk("c_count", 32'(c_cnt), 32'(e.cnt));
                chk("c_ovf", {31'b0, c_ovf}, {31'b0, e.ovf});
                if (e.cyc >= 0) chk("c_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drives one beat from posedge+1, returns at posedge+1 after the beat is taken.
    task automatic send_a(input logic [8*DW-1:0] d, input logic last);
        int n = 0;
        a_data  = d;
        a_valid = 1'b1;
        a_last  = last;
        @(negedge clk);
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            checks++; errors++;
            $display("FAIL a_send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        a_acc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic send_b(input logic [5*DW-1:0] d, input logic last);
        int n = 0;
        b_data  = d;
        b_valid = 1'b1;
        b_last  = last;
        @(negedge clk);
        while (!b_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b_ready) begin
            checks++; errors++;
            $display("FAIL b_send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        b_acc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        a_last  = 1'b0;
        b_valid = 1'b0;
        b_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    function automatic logic [8*DW-1:0] ramp8();
        logic [8*DW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*DW +: DW] = 16'(i + 1);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_valid", {31'b0, a_ovalid}, 32'd0);
        chk("rst_a_sum", a_sum, 32'd0);
        chk("rst_a_count", 32'(a_cnt), 32'd0);
        chk("rst_a_ovf", {31'b0, a_ovf}, 32'd0);
        chk("rst_a_ready", {31'b0, a_ready}, 32'd1);
        chk("rst_b_valid", {31'b0, b_ovalid}, 32'd0);
        chk("rst_c_valid", {31'b0, c_ovalid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Single beat 1..8 -> 36, latency t+4.
        send_a(ramp8(), 1'b1);
        qa.push_back(mk(32'd36, 1, 1'b0, a_acc + 4));
        qc.push_back(mk(32'd36, 1, 1'b0, a_acc + 4));

        // Three beats of 0xFFFF lanes: 24 * 0xFFFF = 0x17FFE8.
        send_a({8{16'hFFFF}}, 1'b0);
        send_a({8{16'hFFFF}}, 1'b0);
        send_a({8{16'hFFFF}}, 1'b1);
        qa.push_back(mk(32'h0017FFE8, 3, 1'b0, a_acc + 4));
`ifdef SUM_SAT_EN
        qc.push_back(mk(32'h000FFFFF, 3, 1'b1, a_acc + 4));
`else
        qc.push_back(mk(32'h0007FFE8, 3, 1'b0, a_acc + 4));
`endif

        // Clean row directly after the overflowing one.
        send_a({8{16'd1}}, 1'b1);
        qa.push_back(mk(32'd8, 1, 1'b0, a_acc + 4));
        qc.push_back(mk(32'd8, 1, 1'b0, a_acc + 4));

        // Gap inside a row with a stray in_last while in_valid=0: 8 + 16 = 24.
        send_a({8{16'd1}}, 1'b0);
        a_valid = 1'b0;
        a_last  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_a({8{16'd2}}, 1'b1);
        qa.push_back(mk(32'd24, 2, 1'b0, a_acc + 4));
        qc.push_back(mk(32'd24, 2, 1'b0, a_acc + 4));
        idle(1);
        drain();

        // Five-lane instance: 10+20+30+40+50 = 150, then back-to-back rows of 5.
        send_b({16'd50, 16'd40, 16'd30, 16'd20, 16'd10}, 1'b1);
        qb.push_back(mk(32'd150, 1, 1'b0, b_acc + 4));
        for (int r = 0; r < 3; r++) begin
            send_b({5{16'd1}}, 1'b1);
            qb.push_back(mk(32'd5, 1, 1'b0, b_acc + 4));
        end
        idle(1);
        drain();

        // Backpressure: three single-beat rows stream in while out_ready is low.
        out_ready = 1'b0;
        send_a({8{16'd3}}, 1'b1);
        qa.push_back(mk(32'd24, 1, 1'b0, -1));
        qc.push_back(mk(32'd24, 1, 1'b0, -1));
        send_a({8{16'd4}}, 1'b1);
        qa.push_back(mk(32'd32, 1, 1'b0, -1));
        qc.push_back(mk(32'd32, 1, 1'b0, -1));
        send_a({8{16'd5}}, 1'b1);
        qa.push_back(mk(32'd40, 1, 1'b0, -1));
        qc.push_back(mk(32'd40, 1, 1'b0, -1));
        idle(0);
        n = 0;
        @(negedge clk);
        while (!a_ovalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_a_valid", {31'b0, a_ovalid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready", {31'b0, a_ready}, 32'd0);
            chk("stall_a_sum_held", a_sum, 32'd24);
            chk("stall_c_sum_held", 32'(c_sum), 32'd24);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Reset after two beats of a three-beat row: nothing must come out.
        send_a({8{16'd7}}, 1'b0);
        send_a({8{16'd7}}, 1'b0);
        idle(1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        chk("post_rst_a_valid", {31'b0, a_ovalid}, 32'd0);
        chk("post_rst_a_sum", a_sum, 32'd0);
        send_a({8{16'd2}}, 1'b1);
        qa.push_back(mk(32'd16, 1, 1'b0, a_acc + 4));
        qc.push_back(mk(32'd16, 1, 1'b0, a_acc + 4));
        idle(1);
        drain();
        idle(4);

        chk("pending_a", 32'(qa.size()), 32'd0);
        chk("pending_b", 32'(qb.size()), 32'd0);
        chk("pending_c", 32'(qc.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
